sdram_dl_port: RTL and testbench

- Upstream feeder for SDRAM controller port C, the IO-controller port.
- Accepts the byte stream from the ROM/NVRAM download interface and buffers it in a small FIFO.
- Converts each buffered byte into an edge-triggered port-C write using the weC/ackC toggle handshake, and also services single-byte readback (upload/verify) requests through oeC.
- Sits between the IO-controller download logic and the SDRAM controller. It guarantees that request pulses are wide and spaced enough for the controller's once-per-cycle edge sampling.

---
 rtl/sdram_dl_port.sv | 242 ++++++++++++++++++++++++
 tb/tb_sdram_dl_port.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_dl_port.sv
// -----------------------------------------------------------------------------
// sdram_dl_port
//
// Upstream feeder for SDRAM controller port C (the IO-controller port).
// Download bytes are buffered in a small FIFO and each one is turned into an
// edge-triggered port-C write using the weC/ackC toggle handshake. Single-byte
// readback requests are serviced through oeC. Every request is followed by a
// guaranteed low gap so the controller, which samples the request levels only
// once per access slot, always sees a fresh rising edge.
//
// Parameters:
//   DEPTH   - write FIFO entries (power of two, >= 2)
//   MIN_LOW - cycles weC/oeC stay low after each ack (>= controller access 7)
//   BASE    - byte offset added to dl_addr and rd_addr, modulo 2^25
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   dl_wr/dl_addr/dl_data - download byte strobe, address, data
//   rd_req/rd_addr      - readback request strobe and address
//   rd_data/rd_valid    - readback byte and its one-cycle valid pulse
//   busy                - work outstanding (FIFO, FSM or pending read)
//   full                - FIFO holds DEPTH entries
//   overflow            - sticky: a download byte was dropped
//   addrC/weC/dinC/oeC  - port-C request side
//   doutC/ackC          - port-C read data and access-complete toggle
// -----------------------------------------------------------------------------
module sdram_dl_port #(
  parameter int          DEPTH   = 4,
  parameter int          MIN_LOW = 8,
  parameter logic [24:0] BASE    = 25'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        rd_req,
  input  logic [24:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        full,
  output logic        overflow,
  output logic [24:0] addrC,
  output logic        weC,
  output logic [7:0]  dinC,
  output logic        oeC,
  input  logic [7:0]  doutC,
  input  logic        ackC
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MIN_LOW + 1);
  localparam logic [CW-1:0] LOW_INIT = CW'(MIN_LOW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ_W = 2'd1,
    REQ_R = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [32:0]   mem_q [DEPTH];
  logic          rd_pend_q, rd_pend_d;
  logic [24:0]   rd_addr_q, rd_addr_d;
  logic          ack_ref_q, ack_ref_d;
  logic          overflow_q, overflow_d;
  logic [24:0]   addr_q, addr_d;
  logic [7:0]    din_q, din_d;
  logic          we_q, we_d;
  logic          oe_q, oe_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic          empty;
  logic          full_int;
  logic          push;
  logic          pop;
  logic          issue_rd;
  logic          ack_evt;
  logic [32:0]   head;

  // FIFO status from the pointers; the extra MSB distinguishes full from empty.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full_int = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head     = mem_q[rd_ptr_q[AW-1:0]];
    // full is judged before any same-cycle pop, so a push into a full FIFO drops.
    push     = dl_wr && !full_int;
    ack_evt  = (ackC != ack_ref_q);
  end

  // Request FSM next-state and port-C output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    oe_d       = oe_q;
    addr_d     = addr_q;
    din_d      = din_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    pop        = 1'b0;
    issue_rd   = 1'b0;
    case (state_q)
      IDLE: begin
        // Writes win over a pending read.
        if (!empty) begin
          pop     = 1'b1;
          addr_d  = head[32:8];
          din_d   = head[7:0];
          we_d    = 1'b1;
          state_d = REQ_W;
        end else if (rd_pend_q) begin
          issue_rd = 1'b1;
          addr_d   = rd_addr_q;
          oe_d     = 1'b1;
          state_d  = REQ_R;
        end else begin
          state_d = IDLE;
        end
      end
      REQ_W: begin
        if (ack_evt) begin
          we_d    = 1'b0;
          cnt_d   = LOW_INIT;
          state_d = GAP;
        end else begin
          state_d = REQ_W;
        end
      end
      REQ_R: begin
        if (ack_evt) begin
          rd_data_d  = doutC;
          rd_valid_d = 1'b1;
          oe_d       = 1'b0;
          cnt_d      = LOW_INIT;
          state_d    = GAP;
        end else begin
          state_d = REQ_R;
        end
      end
      GAP: begin
        // Low hold so the controller samples a low level before the next edge.
        if (cnt_q == {CW{1'b0}}) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = GAP;
        cnt_d   = LOW_INIT;
        we_d    = 1'b0;
        oe_d    = 1'b0;
      end
    endcase
  end

  // Pointer, pending-read, ack-reference and overflow next values.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    overflow_d = overflow_q | (dl_wr & full_int);
    // A new request landing in the issue cycle re-arms the pending read.
    if (rd_req) begin
      rd_pend_d = 1'b1;
      rd_addr_d = rd_addr + BASE;
    end else if (issue_rd) begin
      rd_pend_d = 1'b0;
      rd_addr_d = rd_addr_q;
    end else begin
      rd_pend_d = rd_pend_q;
      rd_addr_d = rd_addr_q;
    end
    // Reference is frozen while a request is open; stray toggles elsewhere are absorbed.
    if ((state_q == REQ_W) || (state_q == REQ_R)) begin
      ack_ref_d = ack_ref_q;
    end else begin
      ack_ref_d = ackC;
    end
  end

  // FIFO storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {dl_addr + BASE, dl_data};
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= GAP;
      cnt_q      <= LOW_INIT;
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= 25'h0;
      ack_ref_q  <= 1'b0;
      overflow_q <= 1'b0;
      addr_q     <= 25'h0;
      din_q      <= 8'h00;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      ack_ref_q  <= ack_ref_d;
      overflow_q <= overflow_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      we_q       <= we_d;
      oe_q       <= oe_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign addrC    = addr_q;
  assign dinC     = din_q;
  assign weC      = we_q;
  assign oeC      = oe_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign overflow = overflow_q;
  assign full     = full_int;
  assign busy     = !empty || (state_q != IDLE) || rd_pend_q;

endmodule

// File: tb/tb_sdram_dl_port.sv
// -----------------------------------------------------------------------------
// tb_sdram_dl_port
//
// Self-checking bench for sdram_dl_port. A port-C controller model acknowledges
// requests after a fixed latency (or stalls on demand), returns a known
// address-derived byte for reads and logs every request edge. The directed
// sequence and a randomized phase compare those logs against expectations
// built from the download/readback rules.
// -----------------------------------------------------------------------------
module tb_sdram_dl_port;

  localparam int DEPTH   = 4;
  localparam int MIN_LOW = 8;
  localparam int WLAT    = 3;
  localparam int RLAT    = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        rd_req;
  logic [24:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid, busy, full, overflow;
  logic [24:0] addrC;
  logic        weC, oeC;
  logic [7:0]  dinC;
  logic [7:0]  doutC = 8'h00;
  logic        ackC  = 1'b0;

  // Second instance exercising the BASE wrap.
  logic        b_dl_wr;
  logic [24:0] b_dl_addr;
  logic [7:0]  b_dl_data;
  logic        b_rd_req = 1'b0;
  logic [24:0] b_rd_addr = 25'h0;
  logic [7:0]  b_rd_data;
  logic        b_rd_valid, b_busy, b_full, b_overflow;
  logic [24:0] b_addrC;
  logic        b_weC, b_oeC;
  logic [7:0]  b_dinC;
  logic [7:0]  b_doutC = 8'h00;
  logic        b_ackC  = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdram_dl_port #(.DEPTH(DEPTH), .MIN_LOW(MIN_LOW), .BASE(25'h0)) u_dut (
    .clk(clk), .reset(reset), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .full(full), .overflow(overflow), .addrC(addrC), .weC(weC),
    .dinC(dinC), .oeC(oeC), .doutC(doutC), .ackC(ackC)
  );

  sdram_dl_port #(.DEPTH(DEPTH), .MIN_LOW(MIN_LOW), .BASE(25'h1FFFFF0)) u_base (
    .clk(clk), .reset(reset), .dl_wr(b_dl_wr), .dl_addr(b_dl_addr), .dl_data(b_dl_data),
    .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .busy(b_busy), .full(b_full), .overflow(b_overflow), .addrC(b_addrC), .weC(b_weC),
    .dinC(b_dinC), .oeC(b_oeC), .doutC(b_doutC), .ackC(b_ackC)
  );

  // Byte the controller model returns for a read of address a.
  function automatic logic [7:0] rom(input logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // ---------------- controller model / monitor ----------------
  logic        stall = 1'b0;
  int          stray_n = 0;
  int          stray_done = 0;
  int          cyc = 0;
  int          low_cnt = 0;
  int          lat = 0;
  bit          pend = 1'b0;
  logic        prev_we = 1'b0, prev_oe = 1'b0;
  logic [24:0] hold_addr = 25'h0;
  logic [7:0]  hold_din = 8'h00;
  int          unstable = 0;
  int          ack_cyc = 0;

  logic [24:0] w_addr_q[$];
  logic [7:0]  w_data_q[$];
  int          w_low_q[$];
  int          w_cyc_q[$];
  logic [24:0] r_addr_q[$];
  int          r_low_q[$];
  int          r_cyc_q[$];
  logic [7:0]  v_data_q[$];
  int          v_cyc_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (reset) begin
      pend    = 1'b0;
      low_cnt = 0;
      prev_we = 1'b0;
      prev_oe = 1'b0;
    end else begin
      if (weC && !prev_we) begin
        w_addr_q.push_back(addrC);
        w_data_q.push_back(dinC);
        w_low_q.push_back(low_cnt);
        w_cyc_q.push_back(cyc);
        hold_addr = addrC;
        hold_din  = dinC;
        pend = 1'b1;
        lat  = WLAT;
        low_cnt = 0;
      end else if (oeC && !prev_oe) begin
        r_addr_q.push_back(addrC);
        r_low_q.push_back(low_cnt);
        r_cyc_q.push_back(cyc);
        doutC = rom(addrC);
        hold_addr = addrC;
        pend = 1'b1;
        lat  = RLAT;
        low_cnt = 0;
      end else if (!weC && !oeC) begin
        low_cnt = low_cnt + 1;
      end
      if ((weC || oeC) && (addrC !== hold_addr)) unstable = unstable + 1;
      if (weC && (dinC !== hold_din)) unstable = unstable + 1;
      if (pend) begin
        if (lat > 0) begin
          lat = lat - 1;
        end else if (!stall) begin
          ackC    = ~ackC;
          ack_cyc = cyc;
          pend    = 1'b0;
        end
      end
      if (stray_n != stray_done) begin
        ackC = ~ackC;
        stray_done = stray_n;
      end
      if (rd_valid) begin
        v_data_q.push_back(rd_data);
        v_cyc_q.push_back(cyc);
      end
      prev_we = weC;
      prev_oe = oeC;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return w_addr_q.size();
      1:       return r_addr_q.size();
      default: return v_data_q.size();
    endcase
  endfunction

  task automatic wait_q(input string tag, input int k, input int n);
    int b = 0;
    while (qsize(k) < n && b < 3000) begin
      tick(1);
      b++;
    end
    chk(tag, 32'(qsize(k) >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int b = 0;
    while (busy !== 1'b0 && b < 3000) begin
      tick(1);
      b++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic dl(input logic [24:0] a, input logic [7:0] d);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
    tick(1);
    dl_wr = 1'b0;
  endtask

  task automatic rd(input logic [24:0] a);
    rd_req = 1'b1; rd_addr = a;
    tick(1);
    rd_req = 1'b0;
  endtask

  int wi = 0;
  task automatic chk_w(input string tag, input logic [24:0] a, input logic [7:0] d);
    chk({tag, "_addr"}, 32'(w_addr_q[wi]), 32'(a));
    chk({tag, "_data"}, 32'(w_data_q[wi]), 32'(d));
    chk({tag, "_low"},  32'(w_low_q[wi] >= MIN_LOW), 32'd1);
    wi++;
  endtask

  // ---------------- directed + random sequence ----------------
  logic [24:0] ew_addr[$];
  logic [7:0]  ew_data[$];
  logic [24:0] er_addr[$];

  initial begin
    int b;
    int w_base, v_base, r_base, pushed, reads;
    logic [24:0] a;
    logic [7:0]  d;
    reset = 1'b1; dl_wr = 1'b0; dl_addr = 25'h0; dl_data = 8'h00;
    rd_req = 1'b0; rd_addr = 25'h0;
    b_dl_wr = 1'b0; b_dl_addr = 25'h0; b_dl_data = 8'h00;
    tick(3);
    chk("rst_we", 32'(weC), 32'd0);
    chk("rst_oe", 32'(oeC), 32'd0);
    chk("rst_addr", 32'(addrC), 32'd0);
    chk("rst_din", 32'(dinC), 32'd0);
    chk("rst_rdata", 32'(rd_data), 32'd0);
    chk("rst_rvalid", 32'(rd_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    reset = 1'b0;
    tick(1);
    chk("gap_busy", 32'(busy), 32'd1);
    wait_idle("idle0");

    // 1: single write
    dl(25'h000010, 8'hA5);
    wait_q("w1_seen", 0, 1);
    chk_w("w1", 25'h000010, 8'hA5);
    wait_idle("w1_idle");
    chk("w1_we_low", 32'(weC), 32'd0);

    // 2: burst into a stalled controller
    stall = 1'b1;
    dl(25'h0000FF, 8'hEE);
    wait_q("w2_first", 0, 2);
    for (int i = 1; i <= 6; i++) begin
      dl_wr = 1'b1; dl_addr = 25'(32'h100 + i); dl_data = 8'(i);
      tick(1);
    end
    dl_wr = 1'b0;
    chk("w2_full", 32'(full), 32'd1);
    chk("w2_ovf", 32'(overflow), 32'd1);
    stall = 1'b0;
    wait_q("w2_drain", 0, 6);
    chk_w("w2_dummy", 25'h0000FF, 8'hEE);
    for (int i = 1; i <= 4; i++) chk_w("w2_burst", 25'(32'h100 + i), 8'(i));
    wait_idle("w2_idle");
    tick(20);
    chk("w2_dropped", 32'(qsize(0)), 32'd6);
    chk("w2_ovf_sticky", 32'(overflow), 32'd1);
    chk("w2_not_full", 32'(full), 32'd0);

    // 3: readback at the top address
    rd(25'h1FFFFFF);
    wait_q("r3_seen", 1, 1);
    chk("r3_addr", 32'(r_addr_q[0]), 32'h1FFFFFF);
    wait_q("r3_valid", 2, 1);
    chk("r3_data", 32'(v_data_q[0]), 32'h3C);
    chk("r3_latency", 32'(v_cyc_q[0] - ack_cyc), 32'd1);
    wait_idle("r3_idle");
    chk("r3_single", 32'(qsize(2)), 32'd1);

    // 4: write wins over a simultaneous read; BASE wrap on the second instance
    dl_wr = 1'b1; dl_addr = 25'h333; dl_data = 8'h77;
    rd_req = 1'b1; rd_addr = 25'h1000222;
    b_dl_wr = 1'b1; b_dl_addr = 25'h20; b_dl_data = 8'h5A;
    tick(1);
    dl_wr = 1'b0; rd_req = 1'b0; b_dl_wr = 1'b0;
    wait_q("p4_read", 1, 2);
    chk("p4_order", 32'(w_cyc_q[6] < r_cyc_q[1]), 32'd1);
    chk("p4_rd_low", 32'(r_low_q[1] >= MIN_LOW), 32'd1);
    chk_w("p4_w", 25'h333, 8'h77);
    chk("p4_raddr", 32'(r_addr_q[1]), 32'h1000222);
    wait_q("p4_valid", 2, 2);
    chk("p4_rdata", 32'(v_data_q[1]), 32'(rom(25'h1000222)));
    b = 0;
    while (b_weC !== 1'b1 && b < 100) begin tick(1); b++; end
    chk("base_we", 32'(b_weC), 32'd1);
    chk("base_addr", 32'(b_addrC), 32'h0000010);
    chk("base_din", 32'(b_dinC), 32'h5A);
    wait_idle("p4_idle");

    // 5: stray ack while idle is ignored
    stray_n = stray_n + 1;
    tick(3);
    stall = 1'b1;
    dl(25'h444, 8'h99);
    wait_q("s5_seen", 0, 8);
    tick(12);
    chk("s5_hold", 32'(weC), 32'd1);
    stall = 1'b0;
    wait_idle("s5_idle");
    chk("s5_we_low", 32'(weC), 32'd0);
    chk_w("s5_w", 25'h444, 8'h99);

    // 6: reset in the middle of REQ_W
    stall = 1'b1;
    dl(25'h555, 8'h11);
    wait_q("x6_seen", 0, 9);
    dl(25'h666, 8'h22);
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("x6_we", 32'(weC), 32'd0);
    chk("x6_full", 32'(full), 32'd0);
    chk("x6_ovf_clr", 32'(overflow), 32'd0);
    reset = 1'b0;
    stall = 1'b0;
    dl(25'h777, 8'h33);
    wait_q("x6_next", 0, 10);
    chk_w("x6_w", 25'h555, 8'h11);
    chk_w("x6_after", 25'h777, 8'h33);
    wait_idle("x6_idle");
    chk("x6_lost", 32'(qsize(0)), 32'd10);

    // Random phase: writes below bit 24, reads above it
    w_base = qsize(0); v_base = qsize(2); r_base = qsize(1);
    pushed = 0; reads = 0;
    for (int it = 0; it < 80; it++) begin
      int r;
      r = $urandom_range(0, 3);
      if (r < 2 && (pushed - (qsize(0) - w_base)) < DEPTH) begin
        a = 25'($urandom_range(0, 32'hFFFFFF));
        d = 8'($urandom);
        ew_addr.push_back(a + 25'h0);
        ew_data.push_back(d);
        pushed++;
        dl(a, d);
      end else if (r == 2 && reads == (qsize(2) - v_base)) begin
        a = {1'b1, 24'($urandom)};
        er_addr.push_back(a);
        reads++;
        rd(a);
      end else begin
        tick(1);
      end
    end
    wait_idle("rnd_idle");
    chk("rnd_wcount", 32'(qsize(0) - w_base), 32'(pushed));
    chk("rnd_vcount", 32'(qsize(2) - v_base), 32'(reads));
    for (int k = 0; k < pushed && (w_base + k) < qsize(0); k++) begin
      chk("rnd_waddr", 32'(w_addr_q[w_base + k]), 32'(ew_addr[k]));
      chk("rnd_wdata", 32'(w_data_q[w_base + k]), 32'(ew_data[k]));
      chk("rnd_wlow", 32'(w_low_q[w_base + k] >= MIN_LOW), 32'd1);
    end
    for (int k = 0; k < reads && (v_base + k) < qsize(2) && (r_base + k) < qsize(1); k++) begin
      chk("rnd_raddr", 32'(r_addr_q[r_base + k]), 32'(er_addr[k]));
      chk("rnd_rdata", 32'(v_data_q[v_base + k]), 32'(rom(er_addr[k])));
    end
    chk("stable_req", 32'(unstable), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
